pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer: drives stall/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Resolves bus-busy stalls, load-use bubbles, exceptions, interrupts and ERET redirects.
//  Owns the exception control registers (EPC, cause, status). Sits beside the pipeline; reads MEM-stage status.
// PARAMETERS
//  WORD_ADDR_W  30      word-address width (PC, EPC, vector)
//  WORD_DATA_W  32      control-register data width
//  EXP_VECTOR   30'h0   word address of the exception handler
// PORTS
//  clk           in   1            clock; all state updates on rising edge
//  reset         in   1            synchronous, active-high
//  if_busy       in   1            fetch bus access not complete
//  mem_busy      in   1            data bus access not complete
//  ld_hazard     in   1            ID instr uses dst of a load now in EX
//  mem_en        in   1            MEM-stage instruction valid
//  mem_pc        in   WORD_ADDR_W  MEM-stage PC
//  mem_exp_code  in   3            MEM-stage exception code (0 = none)
//  mem_ctrl_op   in   2            MEM-stage ctrl op (ERET = 2'd3)
//  int_req       in   1            level interrupt request
//  cr_we         in   1            control-register write (from MEM stage, mem_en qualified)
//  cr_addr       in   2            0 STATUS, 1 EPC, 2 CAUSE
//  cr_wr_data    in   WORD_DATA_W  write data
//  cr_rd_data    out  WORD_DATA_W  combinational read of cr_addr
//  if_stall, id_stall, ex_stall, mem_stall   out 1 each  hold corresponding pipeline register
//  if_flush, id_flush, ex_flush, mem_flush   out 1 each  bubble corresponding register (ignored while its stall=1)
//  new_pc        out  WORD_ADDR_W  redirect target
//  new_pc_valid  out  1            load new_pc into fetch PC this cycle
// BEHAVIOUR
//  Registers reset to: state RUN, epc 0, cause 0, int_en 0, pre_int_en 0, target 0.
//  While reset=1 outputs forced: all stalls 0, all flushes 1, new_pc_valid 0, cr_rd_data 0.
//  Event evt = mem_en & (mem_exp_code!=0 | mem_ctrl_op==ERET | (int_req & int_en)).
//  Priority in RUN: evt > busy (if_busy|mem_busy) > ld_hazard > none.
//  States:
//   RUN:  evt & !mem_busy -> assert all 4 flushes + if_stall; latch; -> REDIRECT.
//         evt & mem_busy  -> all 4 stalls; latch; -> DRAIN.
//         busy (no evt)   -> all 4 stalls, no flush; stay.
//         ld_hazard       -> if_stall=1, id_flush=1 (bubble into ID/EX); stay.
//   DRAIN: all 4 stalls until mem_busy=0; that cycle all flushes + if_stall; -> REDIRECT.
//          int_req dropping in DRAIN has no effect (cause already latched).
//   REDIRECT (exactly 1 cycle): new_pc_valid=1, new_pc=target, all 4 flushes, no stalls; -> RUN.
//          evt ignored in REDIRECT.
//  Latch on evt:
//   exception/interrupt: epc<=mem_pc; cause<=exp code (interrupt = 3'd1, precedes synchronous code);
//     pre_int_en<=int_en; int_en<=0; target<=EXP_VECTOR.
//   ERET (no exception): target<=epc; int_en<=pre_int_en; epc/cause unchanged.
//  Same-cycle evt and cr_we: evt latch wins; the write is dropped.
//  cr_we in RUN without evt: STATUS bit0 -> int_en, bit1 -> pre_int_en; EPC <= wr_data[WORD_ADDR_W-1:0]; CAUSE <= wr_data[2:0].
//  cr_rd_data zero-extended; STATUS = {30'b0, pre_int_en, int_en}.
//  new_pc = 0 when new_pc_valid=0. No other output latency; all outputs combinational from state + inputs.
//  Reset asserted in DRAIN/REDIRECT: abandons redirect, returns to RUN next cycle.
// STRUCTURE
//  Shared package cpu_pkg: state encoding (RUN/DRAIN/REDIRECT), ISA exception codes,
//  CTRL_OP encodings (incl. ERET), CREG address constants.
//  One sub-module: pipe_ctrl_creg (EPC/CAUSE/STATUS regs with latch, write and read mux); FSM stays in pipe_ctrl.
// TESTING
//  ld_hazard=1 one cycle, idle otherwise -> if_stall=1, id_flush=1 that cycle only; other stalls/flushes 0.
//  mem_busy=1 for 3 cycles, no evt -> all 4 stalls high exactly 3 cycles, no flush.
//  mem_en=1, mem_exp_code=3'd2, mem_pc=30'h40, int_en=1 -> same cycle flushes; next cycle new_pc_valid=1,
//    new_pc=EXP_VECTOR; epc=30'h40, cause=2, int_en=0, pre_int_en=1.
//  Exception with mem_busy=1 for 2 cycles -> DRAIN 2 cycles (all stalls), then flush cycle, then REDIRECT.
//  ERET after above -> REDIRECT with new_pc=30'h40, int_en restored to 1.
//  int_req=1 with int_en=0 -> no redirect; cr_we STATUS=1 -> next cycle interrupt taken, cause=1; same-cycle cr_we+evt drops write.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings for the pipeline sequencer: sequencer state,
//                exception codes, MEM-stage control ops and control-register
//                addresses.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   // Sequencer state encoding
   localparam int C_STATE_W = 2;
   typedef logic [C_STATE_W-1:0] state_t;
   localparam state_t C_ST_RUN      = 2'd0;
   localparam state_t C_ST_DRAIN    = 2'd1;
   localparam state_t C_ST_REDIRECT = 2'd2;

   // Exception cause codes (0 means no exception; 1 is reserved for interrupts)
   localparam int C_EXP_CODE_W = 3;
   typedef logic [C_EXP_CODE_W-1:0] exp_code_t;
   localparam exp_code_t C_EXP_NONE     = 3'd0;
   localparam exp_code_t C_EXP_INT      = 3'd1;
   localparam exp_code_t C_EXP_UNDEF    = 3'd2;
   localparam exp_code_t C_EXP_OVERFLOW = 3'd3;
   localparam exp_code_t C_EXP_MISALIGN = 3'd4;
   localparam exp_code_t C_EXP_PRV      = 3'd5;
   localparam exp_code_t C_EXP_TRAP     = 3'd6;

   // MEM-stage control operations
   typedef logic [1:0] ctrl_op_t;
   localparam ctrl_op_t C_CTRL_OP_NOP  = 2'd0;
   localparam ctrl_op_t C_CTRL_OP_WRCR = 2'd1;
   localparam ctrl_op_t C_CTRL_OP_EXIT = 2'd2;
   localparam ctrl_op_t C_CTRL_OP_ERET = 2'd3;

   // Control-register addresses
   typedef logic [1:0] creg_addr_t;
   localparam creg_addr_t C_CREG_STATUS = 2'd0;
   localparam creg_addr_t C_CREG_EPC    = 2'd1;
   localparam creg_addr_t C_CREG_CAUSE  = 2'd2;

   // True when the MEM-stage op requests a return from exception
   function automatic logic is_eret(input ctrl_op_t op);
      return (op == C_CTRL_OP_ERET);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_creg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_creg
//  Description : Exception control registers (EPC, CAUSE, STATUS) with the
//                exception/ERET latch, software write port and read mux.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl_creg
   import cpu_pkg::*;
#(
   parameter int WORD_ADDR_W = 30,
   parameter int WORD_DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   latch_exc,
   input  logic                   latch_eret,
   input  logic [WORD_ADDR_W-1:0] exc_pc,
   input  logic [2:0]             exc_code,
   input  logic                   wr_en,
   input  logic [1:0]             addr,
   input  logic [WORD_DATA_W-1:0] wr_data,
   output logic [WORD_DATA_W-1:0] rd_data,
   output logic [WORD_ADDR_W-1:0] epc,
   output logic                   int_en
);

   logic [WORD_ADDR_W-1:0] r_epc;
   logic [2:0]             r_cause;
   logic                   r_int_en;
   logic                   r_pre_int_en;
   logic                   w_unused_wr_hi;

   // Only the low address bits of a write land in EPC
   assign w_unused_wr_hi = ^wr_data[WORD_DATA_W-1:WORD_ADDR_W];

   // Register update: an event latch always beats a same-cycle software write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epc        <= '0;
         r_cause      <= '0;
         r_int_en     <= 1'b0;
         r_pre_int_en <= 1'b0;
      end else if (latch_exc) begin
         r_epc        <= exc_pc;
         r_cause      <= exc_code;
         r_pre_int_en <= r_int_en;
         r_int_en     <= 1'b0;
      end else if (latch_eret) begin
         r_int_en     <= r_pre_int_en;
      end else if (wr_en) begin
         case (addr)
            C_CREG_STATUS: begin
               r_int_en     <= wr_data[0];
               r_pre_int_en <= wr_data[1];
            end
            C_CREG_EPC:   r_epc   <= wr_data[WORD_ADDR_W-1:0];
            C_CREG_CAUSE: r_cause <= wr_data[2:0];
            default: ;
         endcase
      end
   end

   // Zero-extended read mux; reads return 0 while reset is held
   always_comb begin
      rd_data = '0;
      if (!reset) begin
         case (addr)
            C_CREG_STATUS: rd_data = {{(WORD_DATA_W-2){1'b0}}, r_pre_int_en, r_int_en};
            C_CREG_EPC:    rd_data = {{(WORD_DATA_W-WORD_ADDR_W){1'b0}}, r_epc};
            C_CREG_CAUSE:  rd_data = {{(WORD_DATA_W-3){1'b0}}, r_cause};
            default:       rd_data = '0;
         endcase
      end
   end

   assign epc    = r_epc;
   assign int_en = r_int_en;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central pipeline sequencer. Generates stall/flush for the
//                IF/ID, ID/EX, EX/MEM and MEM/WB registers, resolves bus
//                stalls, load-use bubbles, exceptions, interrupts and ERET
//                redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
   import cpu_pkg::*;
#(
   parameter int                    WORD_ADDR_W = 30,
   parameter int                    WORD_DATA_W = 32,
   parameter logic [WORD_ADDR_W-1:0] EXP_VECTOR = 30'h0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   if_busy,
   input  logic                   mem_busy,
   input  logic                   ld_hazard,
   input  logic                   mem_en,
   input  logic [WORD_ADDR_W-1:0] mem_pc,
   input  logic [2:0]             mem_exp_code,
   input  logic [1:0]             mem_ctrl_op,
   input  logic                   int_req,
   input  logic                   cr_we,
   input  logic [1:0]             cr_addr,
   input  logic [WORD_DATA_W-1:0] cr_wr_data,
   output logic [WORD_DATA_W-1:0] cr_rd_data,
   output logic                   if_stall,
   output logic                   id_stall,
   output logic                   ex_stall,
   output logic                   mem_stall,
   output logic                   if_flush,
   output logic                   id_flush,
   output logic                   ex_flush,
   output logic                   mem_flush,
   output logic [WORD_ADDR_W-1:0] new_pc,
   output logic                   new_pc_valid
);

   // Stall/flush vectors ordered {IF, ID, EX, MEM}
   localparam logic [3:0] C_ALL  = 4'b1111;
   localparam logic [3:0] C_NONE = 4'b0000;
   localparam logic [3:0] C_IF   = 4'b1000;
   localparam logic [3:0] C_ID   = 4'b0100;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [WORD_ADDR_W-1:0] r_target;
   logic [WORD_ADDR_W-1:0] w_epc;
   logic                   w_int_en;
   logic                   w_int;
   logic                   w_exc;
   logic                   w_eret;
   logic                   w_evt;
   logic                   w_take;
   logic                   w_latch_exc;
   logic                   w_latch_eret;
   logic                   w_cr_wr;
   logic [2:0]             w_exc_code;
   logic [3:0]             w_stall;
   logic [3:0]             w_flush;

   // Event decode: an enabled interrupt outranks any synchronous code
   assign w_int      = int_req & w_int_en;
   assign w_exc      = mem_en & ((mem_exp_code != C_EXP_NONE) | w_int);
   assign w_eret     = mem_en & is_eret(mem_ctrl_op) & ~w_exc;
   assign w_evt      = w_exc | w_eret;
   assign w_exc_code = w_int ? C_EXP_INT : mem_exp_code;

   // Events are only acted on (and latched) while running; DRAIN/REDIRECT ignore them
   assign w_take       = (r_state == C_ST_RUN) & w_evt;
   assign w_latch_exc  = w_take & w_exc;
   assign w_latch_eret = w_take & w_eret;
   assign w_cr_wr      = cr_we & (r_state == C_ST_RUN) & ~w_evt;

   pipe_ctrl_creg #(
      .WORD_ADDR_W (WORD_ADDR_W),
      .WORD_DATA_W (WORD_DATA_W)
   ) u_creg (
      .clk        (clk),
      .reset      (reset),
      .latch_exc  (w_latch_exc),
      .latch_eret (w_latch_eret),
      .exc_pc     (mem_pc),
      .exc_code   (w_exc_code),
      .wr_en      (w_cr_wr),
      .addr       (cr_addr),
      .wr_data    (cr_wr_data),
      .rd_data    (cr_rd_data),
      .epc        (w_epc),
      .int_en     (w_int_en)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= C_ST_RUN;
      else       r_state <= w_next_state;
   end

   // Redirect target captured together with the event
   always_ff @(posedge clk) begin
      if (reset)             r_target <= '0;
      else if (w_latch_exc)  r_target <= EXP_VECTOR;
      else if (w_latch_eret) r_target <= w_epc;
   end

   // Next-state logic: an event waits in DRAIN until the data bus is free
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         C_ST_RUN: begin
            if (w_evt) w_next_state = mem_busy ? C_ST_DRAIN : C_ST_REDIRECT;
         end
         C_ST_DRAIN: begin
            if (!mem_busy) w_next_state = C_ST_REDIRECT;
         end
         C_ST_REDIRECT: w_next_state = C_ST_RUN;
         default:       w_next_state = C_ST_RUN;
      endcase
   end

   // Output logic: stall/flush/redirect decoded from state and live inputs
   always_comb begin
      w_stall      = C_NONE;
      w_flush      = C_NONE;
      new_pc_valid = 1'b0;
      new_pc       = '0;
      if (reset) begin
         w_flush = C_ALL;
      end else begin
         case (r_state)
            C_ST_RUN: begin
               if (w_evt) begin
                  if (mem_busy) begin
                     w_stall = C_ALL;
                  end else begin
                     w_flush = C_ALL;
                     w_stall = C_IF;
                  end
               end else if (if_busy | mem_busy) begin
                  w_stall = C_ALL;
               end else if (ld_hazard) begin
                  w_stall = C_IF;
                  w_flush = C_ID;
               end
            end
            C_ST_DRAIN: begin
               if (mem_busy) begin
                  w_stall = C_ALL;
               end else begin
                  w_flush = C_ALL;
                  w_stall = C_IF;
               end
            end
            C_ST_REDIRECT: begin
               new_pc_valid = 1'b1;
               new_pc       = r_target;
               w_flush      = C_ALL;
            end
            default: w_flush = C_ALL;
         endcase
      end
   end

   assign if_stall  = w_stall[3];
   assign id_stall  = w_stall[2];
   assign ex_stall  = w_stall[1];
   assign mem_stall = w_stall[0];
   assign if_flush  = w_flush[3];
   assign id_flush  = w_flush[2];
   assign ex_flush  = w_flush[1];
   assign mem_flush = w_flush[0];

endmodule
`default_nettype wire
